// File: rtl/cm0_dap_dp_ap_seq.sv
// DP-domain sequencer: runs one DP-to-AP access at a time over the DP/AP CDC
// boundary, driving launch enables, the four-phase req/ack handshake and capture masks.
module cm0_dap_dp_ap_seq #(
   parameter int unsigned PRESENT = 1,
   parameter int unsigned WCW     = 8
) (
   input  logic            swclktck,
   input  logic            dpreset_n,
   input  logic            acc_valid_i,
   input  logic            acc_rnw_i,
   input  logic [3:0]      acc_addr_i,
   input  logic [31:0]     acc_wdata_i,
   input  logic            abort_i,
   output logic            acc_busy_o,
   output logic            acc_done_o,
   output logic            acc_aborted_o,
   output logic [31:0]     acc_rdata_o,
   output logic            acc_err_o,
   output logic [WCW-1:0]  wait_cnt_o,
   output logic            dp_wr_en_o,
   output logic            dp_rnw_dp_o,
   output logic [3:0]      dp_regaddr_dp_o,
   output logic [31:0]     dp_data_dp_o,
   output logic            dp_req_dp_load_o,
   output logic            dp_req_dp_next_o,
   output logic            dp_out_en_o,
   output logic            dp_err_out_en_o,
   input  logic            ap_ack_dp_i,
   input  logic [31:0]     ap_data_dp_i,
   input  logic            ap_err_dp_i
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LAUNCH   = 3'd1,
      S_REQ_WAIT = 3'd2,
      S_CAPT     = 3'd3,
      S_ACK_WAIT = 3'd4
   } state_t;

   generate
      if (PRESENT != 0) begin : g_seq
         localparam logic [WCW-1:0] WCNT_MAX = '1;

         state_t          r_state;
         state_t          w_next;
         logic            r_rnw;
         logic            r_aborted;
         logic [WCW-1:0]  r_wcnt;
         logic            r_done;
         logic            r_aborted_p;
         logic [31:0]     r_rdata;
         logic            r_err;
         logic [WCW-1:0]  r_wait_cnt;

         logic            w_accept;
         logic            w_abort;
         logic            w_req_load;
         logic            w_req_next;
         logic            w_mask_en;
         logic            w_finish;

         // Gated by reset so the launch enable is quiet while reset is held.
         assign w_accept = dpreset_n & (r_state == S_IDLE) & acc_valid_i & ~ap_ack_dp_i;
         assign w_abort  = r_aborted | abort_i;

         // Next-state and handshake control decode
         always_comb begin
            w_next     = r_state;
            w_req_load = 1'b0;
            w_req_next = 1'b0;
            w_mask_en  = 1'b0;
            w_finish   = 1'b0;
            case (r_state)
               S_IDLE: begin
                  if (w_accept) w_next = S_LAUNCH;
               end
               S_LAUNCH: begin
                  w_req_load = 1'b1;
                  w_req_next = 1'b1;
                  w_next     = S_REQ_WAIT;
               end
               S_REQ_WAIT: begin
                  if (ap_ack_dp_i) w_next = S_CAPT;
               end
               S_CAPT: begin
                  w_mask_en  = 1'b1;
                  w_req_load = 1'b1;
                  w_req_next = 1'b0;
                  w_next     = S_ACK_WAIT;
               end
               S_ACK_WAIT: begin
                  if (!ap_ack_dp_i) begin
                     w_finish = 1'b1;
                     w_next   = S_IDLE;
                  end
               end
               default: w_next = S_IDLE;
            endcase
         end

         always_ff @(posedge swclktck or negedge dpreset_n) begin
            if (!dpreset_n) r_state <= S_IDLE;
            else            r_state <= w_next;
         end

         // Access context, wait counter and held results
         always_ff @(posedge swclktck or negedge dpreset_n) begin
            if (!dpreset_n) begin
               r_rnw       <= 1'b0;
               r_aborted   <= 1'b0;
               r_wcnt      <= '0;
               r_done      <= 1'b0;
               r_aborted_p <= 1'b0;
               r_rdata     <= '0;
               r_err       <= 1'b0;
               r_wait_cnt  <= '0;
            end else begin
               r_done      <= 1'b0;
               r_aborted_p <= 1'b0;
               if (w_accept) begin
                  r_rnw     <= acc_rnw_i;
                  r_aborted <= 1'b0;
                  r_wcnt    <= '0;
               end else if ((r_state != S_IDLE) && abort_i) begin
                  r_aborted <= 1'b1;
               end
               if ((r_state == S_REQ_WAIT) && (r_wcnt != WCNT_MAX)) begin
                  r_wcnt <= r_wcnt + WCW'(1);
               end
               if ((r_state == S_CAPT) && !w_abort) begin
                  if (r_rnw) r_rdata <= ap_data_dp_i;
                  r_err <= ap_err_dp_i;
               end
               if (w_finish) begin
                  r_done      <= ~w_abort;
                  r_aborted_p <= w_abort;
                  r_wait_cnt  <= r_wcnt;
               end
            end
         end

         assign acc_busy_o       = (r_state != S_IDLE);
         assign acc_done_o       = r_done;
         assign acc_aborted_o    = r_aborted_p;
         assign acc_rdata_o      = r_rdata;
         assign acc_err_o        = r_err;
         assign wait_cnt_o       = r_wait_cnt;
         assign dp_wr_en_o       = w_accept;
         assign dp_rnw_dp_o      = w_accept & acc_rnw_i;
         assign dp_regaddr_dp_o  = w_accept ? acc_addr_i  : 4'h0;
         assign dp_data_dp_o     = w_accept ? acc_wdata_i : 32'h0;
         assign dp_req_dp_load_o = w_req_load;
         assign dp_req_dp_next_o = w_req_next;
         assign dp_out_en_o      = w_mask_en;
         assign dp_err_out_en_o  = w_mask_en;
      end else begin : g_absent
         assign acc_busy_o       = 1'b0;
         assign acc_done_o       = 1'b0;
         assign acc_aborted_o    = 1'b0;
         assign acc_rdata_o      = 32'h0;
         assign acc_err_o        = 1'b0;
         assign wait_cnt_o       = '0;
         assign dp_wr_en_o       = 1'b0;
         assign dp_rnw_dp_o      = 1'b0;
         assign dp_regaddr_dp_o  = 4'h0;
         assign dp_data_dp_o     = 32'h0;
         assign dp_req_dp_load_o = 1'b0;
         assign dp_req_dp_next_o = 1'b0;
         assign dp_out_en_o      = 1'b0;
         assign dp_err_out_en_o  = 1'b0;
      end
   endgenerate

endmodule

// File: tb/tb_cm0_dap_dp_ap_seq.sv
// Scoreboard bench for cm0_dap_dp_ap_seq: the bench plays both the DP engine and
// the AP side of the handshake; a monitor pops expected launches/completions.
module tb_cm0_dap_dp_ap_seq;

   localparam int unsigned WCW  = 8;
   localparam int          WMAX = (1 << WCW) - 1;

   logic            clk = 1'b0;
   logic            dpreset_n;
   logic            acc_valid_i, acc_rnw_i, abort_i;
   logic [3:0]      acc_addr_i;
   logic [31:0]     acc_wdata_i;
   logic            acc_busy_o, acc_done_o, acc_aborted_o, acc_err_o;
   logic [31:0]     acc_rdata_o;
   logic [WCW-1:0]  wait_cnt_o;
   logic            dp_wr_en_o, dp_rnw_dp_o, dp_req_dp_load_o, dp_req_dp_next_o;
   logic [3:0]      dp_regaddr_dp_o;
   logic [31:0]     dp_data_dp_o;
   logic            dp_out_en_o, dp_err_out_en_o;
   logic            ap_ack_dp_i, ap_err_dp_i;
   logic [31:0]     ap_data_dp_i;

   cm0_dap_dp_ap_seq #(.PRESENT(1), .WCW(WCW)) dut (
      .swclktck(clk), .dpreset_n(dpreset_n),
      .acc_valid_i(acc_valid_i), .acc_rnw_i(acc_rnw_i), .acc_addr_i(acc_addr_i),
      .acc_wdata_i(acc_wdata_i), .abort_i(abort_i),
      .acc_busy_o(acc_busy_o), .acc_done_o(acc_done_o), .acc_aborted_o(acc_aborted_o),
      .acc_rdata_o(acc_rdata_o), .acc_err_o(acc_err_o), .wait_cnt_o(wait_cnt_o),
      .dp_wr_en_o(dp_wr_en_o), .dp_rnw_dp_o(dp_rnw_dp_o), .dp_regaddr_dp_o(dp_regaddr_dp_o),
      .dp_data_dp_o(dp_data_dp_o), .dp_req_dp_load_o(dp_req_dp_load_o),
      .dp_req_dp_next_o(dp_req_dp_next_o), .dp_out_en_o(dp_out_en_o),
      .dp_err_out_en_o(dp_err_out_en_o), .ap_ack_dp_i(ap_ack_dp_i),
      .ap_data_dp_i(ap_data_dp_i), .ap_err_dp_i(ap_err_dp_i)
   );

   always #5 clk = ~clk;

   typedef struct { bit rnw; logic [3:0] addr; logic [31:0] data; } launch_t;
   typedef struct { bit aborted; logic [31:0] rdata; bit err; int wcnt; } compl_t;

   launch_t     launch_q[$];
   compl_t      compl_q[$];
   int          checks = 0;
   int          errors = 0;

   // Reference state: what the held result outputs should show.
   logic [31:0] m_rdata = 32'h0;
   bit          m_err   = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares DUT-presented events against queued expectations.
   bit prev_wr = 1'b0;
   int out_cnt = 0;
   always @(negedge clk) begin
      if (!dpreset_n) begin
         prev_wr = 1'b0;
      end else begin
         if (prev_wr) chk("req_raise", {dp_req_dp_load_o, dp_req_dp_next_o}, 64'h3);
         prev_wr = dp_wr_en_o;
         if (dp_wr_en_o) begin
            out_cnt = 0;
            if (launch_q.size() == 0) begin
               chk("unexpected_launch", 64'h1, 64'h0);
            end else begin
               launch_t l;
               l = launch_q.pop_front();
               chk("launch_rnw",  64'(dp_rnw_dp_o),     64'(l.rnw));
               chk("launch_addr", 64'(dp_regaddr_dp_o), 64'(l.addr));
               chk("launch_data", 64'(dp_data_dp_o),    64'(l.data));
            end
         end
         if (dp_out_en_o || dp_err_out_en_o) begin
            out_cnt++;
            chk("capt_ctrl", {dp_out_en_o, dp_err_out_en_o, dp_req_dp_load_o, dp_req_dp_next_o}, 64'hE);
         end
         if (acc_done_o || acc_aborted_o) begin
            if (compl_q.size() == 0) begin
               chk("unexpected_completion", 64'h1, 64'h0);
            end else begin
               compl_t c;
               c = compl_q.pop_front();
               chk("done_kind", {acc_done_o, acc_aborted_o}, {62'h0, !c.aborted, c.aborted});
               chk("rdata",     64'(acc_rdata_o), 64'(c.rdata));
               chk("err",       64'(acc_err_o),   64'(c.err));
               chk("wait_cnt",  64'(wait_cnt_o),  64'(c.wcnt));
               chk("out_en_cycles", 64'(out_cnt), 64'h1);
            end
         end
      end
   end

   function automatic logic [63:0] all_outs();
      return {acc_busy_o, acc_done_o, acc_aborted_o, acc_err_o, dp_wr_en_o, dp_rnw_dp_o,
              dp_req_dp_load_o, dp_req_dp_next_o, dp_out_en_o, dp_err_out_en_o,
              dp_regaddr_dp_o, 24'(wait_cnt_o), |acc_rdata_o, |dp_data_dp_o};
   endfunction

   // One full access: d = REQ_WAIT cycles until ack, k = cycles after req falls
   // until ack drops, ab = REQ_WAIT cycle carrying an abort pulse (0 = none).
   task automatic access(input bit rnw, input logic [3:0] a, input logic [31:0] wd,
                         input logic [31:0] apd, input bit ape,
                         input int d, input int k, input int ab);
      compl_t c;
      launch_t l;
      l.rnw = rnw; l.addr = a; l.data = wd;
      launch_q.push_back(l);
      if (ab == 0) begin
         if (rnw) m_rdata = apd;
         m_err = ape;
      end
      c.aborted = (ab != 0); c.rdata = m_rdata; c.err = m_err;
      c.wcnt = (d > WMAX) ? WMAX : d;
      compl_q.push_back(c);

      acc_valid_i = 1'b1; acc_rnw_i = rnw; acc_addr_i = a; acc_wdata_i = wd;
      abort_i = (ab != 0) && ($urandom_range(0, 1) == 1);   // ignored in IDLE
      @(posedge clk); #1;
      acc_valid_i = 1'b0; abort_i = 1'b0;
      acc_wdata_i = $urandom;
      chk("busy_after_accept", 64'(acc_busy_o), 64'h1);
      @(posedge clk); #1;
      ap_data_dp_i = apd; ap_err_dp_i = ape;
      for (int i = 1; i <= d; i++) begin
         abort_i = (i == ab);
         if (i == d) ap_ack_dp_i = 1'b1;
         @(posedge clk); #1;
      end
      abort_i = 1'b0;
      @(posedge clk); #1;
      ap_data_dp_i = $urandom; ap_err_dp_i = 1'($urandom);
      for (int j = 1; j <= k; j++) begin
         if (j == k) ap_ack_dp_i = 1'b0;
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      dpreset_n = 1'b0;
      acc_valid_i = 1'b0; acc_rnw_i = 1'b0; acc_addr_i = 4'h0; acc_wdata_i = 32'h0;
      abort_i = 1'b0; ap_ack_dp_i = 1'b0; ap_data_dp_i = 32'h0; ap_err_dp_i = 1'b0;
      #12;
      chk("reset_outputs", all_outs(), 64'h0);
      repeat (2) @(posedge clk);
      #1 dpreset_n = 1'b1;
      @(posedge clk); #1;
      chk("idle_after_reset", all_outs(), 64'h0);

      access(1'b0, 4'h4, 32'hDEADBEEF, 32'h11111111, 1'b0, 3, 2, 0);
      access(1'b1, 4'hC, 32'h0, 32'h12345678, 1'b0, 2, 1, 0);
      access(1'b1, 4'h8, 32'h0, 32'h00000000, 1'b1, 4, 3, 0);
      access(1'b1, 4'h0, 32'h0, 32'h55AA33CC, 1'b0, 1, 1, 0);
      access(1'b1, 4'hC, 32'h0, 32'hCAFEF00D, 1'b1, 4, 2, 2);

      // Valid while ack is still high must not be accepted.
      ap_ack_dp_i = 1'b1; acc_valid_i = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk("no_accept_while_ack", {62'h0, acc_busy_o, dp_wr_en_o}, 64'h0);
      acc_valid_i = 1'b0; ap_ack_dp_i = 1'b0;
      @(posedge clk); #1;

      access(1'b0, 4'h2, 32'h0BADF00D, 32'h0, 1'b0, 300, 2, 0);

      // Reset in REQ_WAIT: outputs clear asynchronously, pending completion dropped.
      begin
         launch_t l;
         l.rnw = 1'b1; l.addr = 4'h6; l.data = 32'h77;
         launch_q.push_back(l);
         acc_valid_i = 1'b1; acc_rnw_i = 1'b1; acc_addr_i = 4'h6; acc_wdata_i = 32'h77;
         @(posedge clk); #1 acc_valid_i = 1'b0;
         repeat (2) @(posedge clk);
         #2 dpreset_n = 1'b0;
         #1 chk("mid_access_reset", all_outs(), 64'h0);
         m_rdata = 32'h0; m_err = 1'b0;
         @(posedge clk); #1 dpreset_n = 1'b1;
         @(posedge clk); #1;
      end
      access(1'b1, 4'hA, 32'h0, 32'hA5A5F00F, 1'b0, 2, 1, 0);

      for (int n = 0; n < 25; n++) begin
         int d, ab;
         d  = $urandom_range(1, 6);
         ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, d) : 0;
         access(1'($urandom), 4'($urandom), $urandom, $urandom, 1'($urandom),
                d, $urandom_range(1, 4), ab);
      end

      chk("launch_q_empty", 64'(launch_q.size()), 64'h0);
      chk("compl_q_empty",  64'(compl_q.size()),  64'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
